// File: rtl/arbiter_rr_burst.sv
// Round-robin memory arbiter: single reads and fixed-length write bursts.
// Define ARBITER_RR_PRI0_EN to give requester 0 absolute priority at each arbitration.
module arbiter_rr_burst #(
   parameter int AN    = 24,
   parameter int DN    = 16,
   parameter int N     = 4,
   parameter int IN    = 2,
   parameter int BURST = 8
) (
   input  logic            clkSYS,
   input  logic            n_reset,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    req_wr,
   input  logic [N*AN-1:0] req_addr,
   input  logic [N*DN-1:0] req_data,
   output logic [N-1:0]    req_ack,
   output logic [N-1:0]    rd_valid,
   output logic            mem_req,
   output logic            mem_wr,
   output logic [AN-1:0]   mem_addr,
   output logic [DN-1:0]   mem_data,
   output logic [IN-1:0]   mem_id,
   input  logic            mem_ack,
   input  logic            mem_valid,
   input  logic [IN-1:0]   mem_rid
);

   localparam int CW = $clog2(BURST) + 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t        state, state_nxt;
   logic [IN-1:0] gnt, gnt_nxt;
   logic [IN-1:0] ptr, ptr_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [IN-1:0] winner;
   logic [IN-1:0] cand;
   logic          found;
   logic [IN-1:0] gnt_inc;

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Scan from ptr upward, wrapping at N; the first active request wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         cand = IN'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
`ifdef ARBITER_RR_PRI0_EN
      if (req[0]) begin
         found  = 1'b1;
         winner = '0;
      end
`else
`endif
   end

   assign gnt_inc = (int'(gnt) == N - 1) ? '0 : gnt + IN'(1);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt   = winner;
               cnt_nxt   = '0;
               state_nxt = req_wr[winner] ? WRITE : READ;
            end
         end
         READ: begin
            if (mem_ack) begin
               state_nxt = IDLE;
               ptr_nxt   = gnt_inc;
            end
         end
         WRITE: begin
            // The grant stays put until all BURST words are acked, even if req drops.
            if (mem_ack) begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == CW'(BURST - 1)) begin
                  state_nxt = IDLE;
                  ptr_nxt   = gnt_inc;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ack  = '0;
      mem_req  = 1'b0;
      mem_wr   = 1'b0;
      mem_id   = '0;
      mem_addr = req_addr[int'(gnt)*AN +: AN];
      mem_data = req_data[int'(gnt)*DN +: DN];
      if (state != IDLE) begin
         mem_req      = req[gnt];
         mem_wr       = req_wr[gnt];
         mem_id       = gnt;
         req_ack[gnt] = mem_ack;
      end
   end

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < N; i++) begin
         rd_valid[i] = mem_valid && (mem_rid == IN'(i));
      end
   end

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Directed bench for arbiter_rr_burst; expected grants are queued as stimulus is applied.
module tb_arbiter_rr_burst;

   localparam int AN = 24, DN = 16, N = 4, IN = 2, BURST = 8;

   logic            clkSYS;
   logic            n_reset;
   logic [N-1:0]    req, req_wr;
   logic [N*AN-1:0] req_addr;
   logic [N*DN-1:0] req_data;
   logic [N-1:0]    req_ack, rd_valid;
   logic            mem_req, mem_wr;
   logic [AN-1:0]   mem_addr;
   logic [DN-1:0]   mem_data;
   logic [IN-1:0]   mem_id;
   logic            mem_ack, mem_valid;
   logic [IN-1:0]   mem_rid;

   int vectors = 0;
   int miscompares = 0;
   logic [IN-1:0] exp_gnt[$];

   arbiter_rr_burst #(.AN(AN), .DN(DN), .N(N), .IN(IN), .BURST(BURST)) dut (
      .clkSYS(clkSYS), .n_reset(n_reset), .req(req), .req_wr(req_wr),
      .req_addr(req_addr), .req_data(req_data), .req_ack(req_ack),
      .rd_valid(rd_valid), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_id(mem_id),
      .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rid(mem_rid)
   );

   initial clkSYS = 1'b0;
   always #5 clkSYS = ~clkSYS;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] expAddr(input int i);
      return 32'h100000 + 32'(i) * 32'h111;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w);
      req    = r;
      req_wr = w;
   endtask

   task automatic waitReq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clkSYS);
         if (mem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("req_timeout", 32'd0, 32'd1);
   endtask

   task automatic popExp(output logic [IN-1:0] e);
      if (exp_gnt.size() > 0) e = exp_gnt.pop_front();
      else begin
         e = '0;
         checkOutput("queue_empty", 32'd0, 32'd1);
      end
   endtask

   // Serves one read: ack arrives the cycle after mem_req, then checks return to idle.
   task automatic serveRead(input string tag);
      bit ok;
      logic [IN-1:0] e;
      waitReq(ok);
      if (ok) begin
         popExp(e);
         checkOutput({tag, "_id"}, 32'(mem_id), 32'(e));
         checkOutput({tag, "_addr"}, 32'(mem_addr), expAddr(int'(e)));
         checkOutput({tag, "_wr"}, 32'(mem_wr), 32'd0);
         checkOutput({tag, "_ack_pre"}, 32'(req_ack), 32'd0);
         @(negedge clkSYS);
         mem_ack = 1'b1;
         #1;
         checkOutput({tag, "_ack"}, 32'(req_ack), 32'd1 << e);
         @(negedge clkSYS);
         mem_ack = 1'b0;
         #1;
         checkOutput({tag, "_idle_req"}, 32'(mem_req), 32'd0);
         checkOutput({tag, "_idle_ack"}, 32'(req_ack), 32'd0);
      end
   endtask

   initial begin
      bit ok;
      int pulses;
      logic [IN-1:0] e;

      n_reset = 1'b0;
      applyStimulus(4'b0000, 4'b0000);
      mem_ack = 1'b0;
      mem_valid = 1'b1;
      mem_rid = 2'd2;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AN +: AN] = AN'(expAddr(i));
         req_data[i*DN +: DN] = DN'(16'hA000 + i);
      end

      // Reset values; rd_valid stays live during reset
      repeat (2) @(negedge clkSYS);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
      checkOutput("rst_mem_id", 32'(mem_id), 32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'b0100);
      mem_valid = 1'b0;
      n_reset = 1'b1;

      // All four requesting reads
      applyStimulus(4'b1111, 4'b0000);
`ifdef ARBITER_RR_PRI0_EN
      for (int i = 0; i < 5; i++) exp_gnt.push_back(2'd0);
`else
      exp_gnt.push_back(2'd0); exp_gnt.push_back(2'd1); exp_gnt.push_back(2'd2);
      exp_gnt.push_back(2'd3); exp_gnt.push_back(2'd0);
`endif
      for (int i = 0; i < 5; i++) serveRead("rr");
      applyStimulus(4'b0000, 4'b0000);

      // Read-return decode while requester 1 is granted
      applyStimulus(4'b0010, 4'b0000);
      exp_gnt.push_back(2'd1);
      mem_valid = 1'b1;
      mem_rid = 2'd3;
      waitReq(ok);
      popExp(e);
      checkOutput("rv_id", 32'(mem_id), 32'(e));
      checkOutput("rv_rd_valid", 32'(rd_valid), 32'b1000);
      @(negedge clkSYS);
      mem_ack = 1'b1;
      #1;
      checkOutput("rv_req_ack", 32'(req_ack), 32'b0010);
      @(negedge clkSYS);
      mem_ack = 1'b0;
      mem_valid = 1'b0;
      applyStimulus(4'b0000, 4'b0000);

      // Burst write from 2 with acks every other cycle; requester 1 joins mid-burst
      applyStimulus(4'b0100, 4'b0100);
      exp_gnt.push_back(2'd2);
      waitReq(ok);
      popExp(e);
      checkOutput("wb_id", 32'(mem_id), 32'(e));
      checkOutput("wb_wr", 32'(mem_wr), 32'd1);
      checkOutput("wb_data", 32'(mem_data), 32'hA002);
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
         mem_ack = k[0];
         if (k == 3) req[1] = 1'b1;
         #1;
         checkOutput("wb_hold_id", 32'(mem_id), 32'd2);
         checkOutput("wb_ack", 32'(req_ack), k[0] ? 32'b0100 : 32'd0);
         if (req_ack[2]) pulses++;
         @(negedge clkSYS);
      end
      mem_ack = 1'b0;
      applyStimulus(4'b0010, 4'b0000);
      #1;
      checkOutput("wb_end_req", 32'(mem_req), 32'd0);
      checkOutput("wb_pulses", 32'(pulses), 32'd8);
      exp_gnt.push_back(2'd1);
      serveRead("after_wb");
      applyStimulus(4'b0000, 4'b0000);

      // Write from 3, req dropped mid-burst, then reset after three acks
      applyStimulus(4'b1000, 4'b1000);
      exp_gnt.push_back(2'd3);
      waitReq(ok);
      popExp(e);
      checkOutput("wr3_id", 32'(mem_id), 32'(e));
      for (int k = 0; k < 3; k++) begin
         mem_ack = 1'b1;
         if (k == 1) req = 4'b0000;
         #1;
         checkOutput("wr3_hold_id", 32'(mem_id), 32'd3);
         checkOutput("wr3_ack", 32'(req_ack), 32'b1000);
         checkOutput("wr3_mem_req", 32'(mem_req), (k < 1) ? 32'd1 : 32'd0);
         @(negedge clkSYS);
      end
      mem_ack = 1'b0;
      applyStimulus(4'b0001, 4'b0001);
      @(negedge clkSYS);
      #1;
      checkOutput("wr3_no_steal", 32'(mem_id), 32'd3);
      n_reset = 1'b0;
      #1;
      checkOutput("arst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("arst_mem_id", 32'(mem_id), 32'd0);
      checkOutput("arst_req_ack", 32'(req_ack), 32'd0);
      @(negedge clkSYS);
      n_reset = 1'b1;
      exp_gnt.push_back(2'd0);
      waitReq(ok);
      popExp(e);
      checkOutput("post_rst_id", 32'(mem_id), 32'(e));
      checkOutput("post_rst_wr", 32'(mem_wr), 32'd1);
      for (int k = 0; k < 7; k++) begin
         mem_ack = 1'b1;
         #1;
         checkOutput("post_rst_busy", 32'(mem_req), 32'd1);
         @(negedge clkSYS);
      end
      mem_ack = 1'b1;
      #1;
      checkOutput("post_rst_8th", 32'(mem_req), 32'd1);
      @(negedge clkSYS);
      mem_ack = 1'b0;
      applyStimulus(4'b0000, 4'b0000);
      #1;
      checkOutput("post_rst_done", 32'(mem_req), 32'd0);

      // Requesters 0 and 1 both held, starting from a fresh pointer
      n_reset = 1'b0;
      @(negedge clkSYS);
      n_reset = 1'b1;
      applyStimulus(4'b0011, 4'b0000);
`ifdef ARBITER_RR_PRI0_EN
      for (int i = 0; i < 4; i++) exp_gnt.push_back(2'd0);
`else
      for (int i = 0; i < 4; i++) exp_gnt.push_back(IN'(i % 2));
`endif
      for (int i = 0; i < 4; i++) serveRead("alt");
      applyStimulus(4'b0000, 4'b0000);

      checkOutput("queue_drained", 32'(exp_gnt.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
